// File: rtl/wide_add_sequencer.sv
// Slices a WIDTH-bit add into SLICE-bit steps through an external registered adder, chaining carries.
// Optional signed-overflow output enabled with `define WIDE_ADD_OVF_EN.
module wide_add_sequencer #(
   parameter int WIDTH   = 64,
   parameter int SLICE   = 16,
   parameter int ADD_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             result_cout,
`ifdef WIDE_ADD_OVF_EN
   output logic             ovf,
`endif
   output logic [SLICE-1:0] add_a,
   output logic [SLICE-1:0] add_b,
   output logic             add_cin,
   input  logic [SLICE-1:0] add_sum,
   input  logic             add_cout
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int CW     = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q, b_q;
   logic [IW-1:0]    idx;
   logic [CW-1:0]    cnt;
   logic [IW-1:0]    nxt;

   assign nxt = idx + IW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         idx         <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
         result_cout <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
         ovf         <= 1'b0;
`endif
         add_a       <= '0;
         add_b       <= '0;
         add_cin     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q         <= op_a;
                  b_q         <= op_b;
                  idx         <= '0;
                  cnt         <= '0;
                  add_a       <= op_a[SLICE-1:0];
                  add_b       <= op_b[SLICE-1:0];
                  add_cin     <= op_cin;
                  result      <= '0;
                  result_cout <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
                  ovf         <= 1'b0;
`endif
                  busy        <= 1'b1;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt + CW'(1);
               // add_sum reflects the current slice once ADD_LAT edges have passed since it was driven
               if (cnt == CW'(ADD_LAT)) begin
                  result[int'(idx)*SLICE +: SLICE] <= add_sum;
                  if (idx != IW'(NSLICE - 1)) begin
                     idx     <= nxt;
                     cnt     <= '0;
                     add_a   <= a_q[int'(nxt)*SLICE +: SLICE];
                     add_b   <= b_q[int'(nxt)*SLICE +: SLICE];
                     add_cin <= add_cout;
                  end else begin
                     result_cout <= add_cout;
`ifdef WIDE_ADD_OVF_EN
                     // carry into the MSB is a^b^sum at that bit
                     ovf <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ add_sum[SLICE-1] ^ add_cout;
`endif
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer with a behavioural two-stage registered 16-bit adder.
`timescale 1ps/1ps
module tb_wide_add_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [63:0] op_a = '0, op_b = '0;
   logic        op_cin = 1'b0;
   logic        busy, done, result_cout;
   logic [63:0] result;
   logic [15:0] add_a, add_b, add_sum;
   logic        add_cin, add_cout;
`ifdef WIDE_ADD_OVF_EN
   logic        ovf;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int edges;
   int base;

   always #650 clk = ~clk;

   wide_add_sequencer #(.WIDTH(64), .SLICE(16), .ADD_LAT(2)) dut (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
      .busy(busy), .done(done), .result(result), .result_cout(result_cout),
`ifdef WIDE_ADD_OVF_EN
      .ovf(ovf),
`endif
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
   );

   // adder model: input register stage then output register stage
   logic [15:0] ra, rb;
   logic        rc;
   always @(posedge clk) begin
      ra <= add_a;
      rb <= add_b;
      rc <= add_cin;
      {add_cout, add_sum} <= {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
   end

   always @(negedge clk) if (done) done_cnt++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_add(input logic [63:0] a, input logic [63:0] b, input logic cin);
      @(negedge clk);
      op_a = a; op_b = b; op_cin = cin; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int already, output int n);
      n = already;
      while (!done && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
   endtask

   task automatic after_done(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
      check({tag, "_done_after"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      #100;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_add_a", {48'd0, add_a}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // 1: carry out of slice 0 into slice 1
      start_add(64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
      check("t1_busy", {63'd0, busy}, 64'd1);
      wait_done(0, edges);
      check("t1_latency", 64'(edges), 64'd12);
      check("t1_result", result, 64'h0000_0000_0001_0000);
      check("t1_cout", {63'd0, result_cout}, 64'd0);
      after_done("t1");
      check("t1_hold", result, 64'h0000_0000_0001_0000);

      // 2: carry ripples through all four slices
      start_add(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      check("t2_cleared", result, 64'd0);
      wait_done(0, edges);
      check("t2_latency", 64'(edges), 64'd12);
      check("t2_result", result, 64'd0);
      check("t2_cout", {63'd0, result_cout}, 64'd1);
`ifdef WIDE_ADD_OVF_EN
      check("t2_ovf", {63'd0, ovf}, 64'd0);
`endif
      after_done("t2");

      // 3: mixed operands with carry-in
      start_add(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
      check("t3_add_a0", {48'd0, add_a}, 64'h0000_0000_0000_DEF0);
      check("t3_add_cin0", {63'd0, add_cin}, 64'd1);
      wait_done(0, edges);
      check("t3_result", result, 64'h2222_2222_2222_2212);
      check("t3_cout", {63'd0, result_cout}, 64'd0);
      after_done("t3");

      // 4: second start during WAIT ignored, operand changes ignored
      base = done_cnt;
      start_add(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      op_a = 64'hFFFF_FFFF_FFFF_FFFF; op_b = 64'hFFFF_FFFF_FFFF_FFFF; op_cin = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(3, edges);
      check("t4_latency", 64'(edges), 64'd12);
      check("t4_result", result, 64'h3333_3333_3333_3333);
      check("t4_cout", {63'd0, result_cout}, 64'd0);
      repeat (6) @(posedge clk);
      #1 check("t4_done_count", 64'(done_cnt - base), 64'd1);
      check("t4_idle", {63'd0, busy}, 64'd0);

      // 5: reset mid-operation at slice index 2
      base = done_cnt;
      start_add(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1);
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("t5_rst_result", result, 64'd0);
      check("t5_rst_busy", {63'd0, busy}, 64'd0);
      check("t5_rst_add_a", {48'd0, add_a}, 64'd0);
      check("t5_rst_add_cin", {63'd0, add_cin}, 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (15) @(posedge clk);
      #1 check("t5_no_done", 64'(done_cnt - base), 64'd0);
      start_add(64'd0, 64'd0, 1'b0);
      wait_done(0, edges);
      check("t5_latency", 64'(edges), 64'd12);
      check("t5_result", result, 64'd0);
      check("t5_cout", {63'd0, result_cout}, 64'd0);
      after_done("t5");

`ifdef WIDE_ADD_OVF_EN
      // 6: signed overflow
      start_add(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      check("t6_ovf_clr", {63'd0, ovf}, 64'd0);
      wait_done(0, edges);
      check("t6_result", result, 64'h8000_0000_0000_0000);
      check("t6_cout", {63'd0, result_cout}, 64'd0);
      check("t6_ovf", {63'd0, ovf}, 64'd1);
      after_done("t6");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
